alu_shift_seq: RTL and testbench
================================

# alu_shift_seq

Iterative, handshaked shift/rotate engine for the templatized ALU. It accepts one 16-bit operation per transaction over a valid/ready command port and moves the operand one bit position per cycle. The result is returned over a valid/ready response port. It uses the same SLL/SAR/ROL/ROR opcode space as the combinational shift slice and is the multi-cycle, area-minimal counterpart for pipelines that issue shift commands and wait on a response.

## Interface
- WIDTH, 16, operand/result width; must be a power of two ≥ 4.
- CNT_W, $clog2(WIDTH)+1, width of the internal step counter; holds 0..WIDTH.
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  engine can accept a command.
- in_a  input  WIDTH  operand.
- in_b  input  WIDTH  shift/rotate amount.
- in_opcode  input  4  0110 SLL, 0111 SAR, 1000 ROL, 1001 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  shifted/rotated value.
- out_err  output  1  the command carried an illegal opcode.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE → SHIFT → DONE → IDLE.
- Accept: in_valid && in_ready in IDLE. On accept, register the operand, opcode and step count N, then enter SHIFT; enter DONE directly when N = 0 or the opcode is illegal.
- Step count N:
  - SLL/SAR: N = min(in_b, WIDTH). The full in_b is compared, so amounts ≥ WIDTH clamp to WIDTH.
  - ROL/ROR: N = in_b mod WIDTH, using the low log2(WIDTH) bits.
- Per SHIFT cycle (one step):
  - SLL: shift left 1, 0 fill.
  - SAR: shift right 1, fill with the current MSB.
  - ROL: the MSB wraps into the LSB.
  - ROR: the LSB wraps into the MSB.
  - Decrement the counter. Leave SHIFT when the counter reaches 1 and that step completes.
- Net results:
  - SLL with amount ≥ WIDTH gives 0.
  - SAR with amount ≥ WIDTH gives all sign bits.
  - A rotate by a multiple of WIDTH returns in_a unchanged.
- Illegal opcode: out_result = 0 and out_err = 1. Every legal command returns out_err = 0.
- DONE:
  - out_valid = 1. out_result and out_err stay stable until out_valid && out_ready.
  - When that handshake occurs, return to IDLE.
- in_ready = 1 only in IDLE. A command cannot be accepted in the same cycle as the result handshake.
- Commands presented while busy are ignored. The issuer must hold in_valid until in_ready is high.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, out_err 0, busy 0, counter 0.
- Reset asserted mid-operation aborts the operation. The in-flight result is discarded and never presented.
- Latency: the accept edge is cycle 0, and out_valid rises at cycle N+1 after the accept. When N = 0 or the opcode is illegal, out_valid rises at cycle 1.
- Throughput: one command per N+2 cycles minimum, with out_ready held high.
- Backpressure: DONE persists indefinitely while out_ready = 0, with no change to out_result or out_err.

## Configuration
- ALU_SHIFT_SEQ_FAST_EN:
  - Defined: each SHIFT cycle moves 4 positions while the counter is ≥ 4, otherwise 1 position. The counter is decremented by the amount moved, so latency is ⌊N/4⌋ + (N mod 4) + 1 cycles to out_valid. Results are identical to the undefined case.
  - Undefined: strictly one position per cycle, latency N+1.

## Test plan
- SLL, in_a=0x0001, in_b=3 → out_result=0x0008, out_err=0. out_valid 4 cycles after accept (4 with FAST, since 3 single steps).
- SAR, in_a=0x8000, in_b=4 → 0xF800. SLL, in_a=0xFFFF, in_b=0x0020 → 0x0000 after the count is clamped to 16 (17 cycles; 5 with FAST).
- ROL, in_a=0x8001, in_b=1 → 0x0003. ROR, in_a=0x0001, in_b=20 → 0x1000 (effective amount 4). ROL, in_b=16 → in_a unchanged, out_valid at cycle 1.
- Illegal opcode 4'b0000, in_a=0x1234 → out_result=0x0000, out_err=1, out_valid at cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_result and in_ready=0 stay stable. A second command offered meanwhile is not accepted until one cycle after the result handshake.
- Reset mid-SHIFT (SLL, in_b=10, rst at cycle 5) → the next cycle shows all outputs at their reset values, with no out_valid pulse. A fresh command then completes correctly.

Source files
------------

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: iterative, handshaked shift/rotate engine.
//
// Takes one command per transaction on a valid/ready port. The operand is shifted or rotated
// one bit position per cycle, and the result is presented on a valid/ready response port.
// Opcodes: 0110 SLL, 0111 SAR, 1000 ROL, 1001 ROR. Any other opcode returns result 0 with
// out_err set.
//
// Optional feature (compile-time macro):
//   ALU_SHIFT_SEQ_FAST_EN - while at least 4 steps remain, each SHIFT cycle moves 4 positions.
//                           Results are identical with or without the macro.
//
// Ports:
//   clk, rst    - clock; synchronous active-high reset
//   in_valid    - command valid
//   in_ready    - engine can accept a command (IDLE only)
//   in_a        - operand
//   in_b        - shift/rotate amount
//   in_opcode   - operation select
//   out_valid   - result valid (DONE state)
//   out_ready   - consumer accepts the result
//   out_result  - shifted/rotated value, held stable while out_valid is high
//   out_err     - the command carried an illegal opcode
//   busy        - high in any state other than IDLE
module alu_shift_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned LogW = $clog2(WIDTH);

  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpSar = 4'b0111;
  localparam logic [3:0] OpRol = 4'b1000;
  localparam logic [3:0] OpRor = 4'b1001;

  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] data;   // working operand; also the presented result
  logic [3:0]       op;
  logic [CNT_W-1:0] cnt;    // steps still to perform
  logic             err;

  logic             legal;
  logic [CNT_W-1:0] n_load;
  logic             big;
  logic [CNT_W-1:0] step_amt;
  logic [WIDTH-1:0] step_data;

  // Command decode and step count.
  always_comb begin
    legal = (in_opcode == OpSll) || (in_opcode == OpSar) ||
            (in_opcode == OpRol) || (in_opcode == OpRor);
    if ((in_opcode == OpRol) || (in_opcode == OpRor)) begin
      // A rotate by a multiple of WIDTH is the identity, so only the low bits matter.
      n_load = CNT_W'(in_b[LogW-1:0]);
    end else if (in_b >= WidthVal) begin
      // Shifting by WIDTH or more saturates; WIDTH single steps gives the same result.
      n_load = CNT_W'(WIDTH);
    end else begin
      n_load = CNT_W'(in_b);
    end
  end

  // One SHIFT-cycle step: move 1 position, or 4 positions in fast mode while at least 4 remain.
  always_comb begin
    big = 1'b0;
`ifdef ALU_SHIFT_SEQ_FAST_EN
    big = (cnt >= CNT_W'(4));
`endif
    step_amt  = big ? CNT_W'(4) : CNT_W'(1);
    step_data = data;
    case (op)
      OpSll: step_data = big ? {data[WIDTH-5:0], 4'b0000}
                             : {data[WIDTH-2:0], 1'b0};
      OpSar: step_data = big ? {{4{data[WIDTH-1]}}, data[WIDTH-1:4]}
                             : {data[WIDTH-1], data[WIDTH-1:1]};
      OpRol: step_data = big ? {data[WIDTH-5:0], data[WIDTH-1:WIDTH-4]}
                             : {data[WIDTH-2:0], data[WIDTH-1]};
      OpRor: step_data = big ? {data[3:0], data[WIDTH-1:4]}
                             : {data[0], data[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      data  <= '0;
      op    <= OpSll;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            if (!legal) begin
              data  <= '0;
              err   <= 1'b1;
              cnt   <= '0;
              state <= StDone;
            end else begin
              data  <= in_a;
              op    <= in_opcode;
              err   <= 1'b0;
              cnt   <= n_load;
              state <= (n_load == '0) ? StDone : StShift;
            end
          end
        end
        StShift: begin
          data <= step_data;
          cnt  <= cnt - step_amt;
          if (cnt == step_amt) begin
            state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state == StIdle);
  assign out_valid  = (state == StDone);
  assign busy       = (state != StIdle);
  assign out_result = data;
  assign out_err    = err;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: expected results are pushed to a scoreboard queue when
// each command is driven and popped when the engine presents its response.
module tb_alu_shift_seq;

  localparam int W = 16;

  localparam logic [3:0] SLL = 4'b0110;
  localparam logic [3:0] SAR = 4'b0111;
  localparam logic [3:0] ROL = 4'b1000;
  localparam logic [3:0] ROR = 4'b1001;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_err;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_shift_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [3:0] op);
    return (op == SLL) || (op == SAR) || (op == ROL) || (op == ROR);
  endfunction

  // Accept edge counts as cycle 0; latency is the cycle in which out_valid is first seen.
  function automatic int lat_of(input logic [W-1:0] b, input logic [3:0] op);
    int n;
    if (!is_legal(op)) return 1;
    if ((op == ROL) || (op == ROR)) n = int'(b) % W;
    else n = (int'(b) >= W) ? W : int'(b);
`ifdef ALU_SHIFT_SEQ_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    logic [2*W-1:0] t;
    int r;
    r = int'(b) % W;
    case (op)
      SLL: return (int'(b) >= W) ? '0 : (a << b);
      SAR: return (int'(b) >= W) ? {W{a[W-1]}} : W'($signed(a) >>> b);
      ROL: begin t = {a, a} << r; return t[2*W-1:W]; end
      ROR: begin t = {a, a} >> r; return t[W-1:0]; end
      default: return '0;
    endcase
  endfunction

  // Drive one command, push its expectation and wait (bounded) for acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                      input logic [W-1:0] xres, input logic xerr, output bit ok);
    exp_t e;
    e.res = xres;
    e.err = xerr;
    e.lat = lat_of(b, op);
    sb.push_back(e);
    in_a = a;
    in_b = b;
    in_opcode = op;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; called #1 after the accept edge. Does not handshake.
  task automatic collect(output logic [W-1:0] res, output logic err, output int lat,
                         output bit to);
    to = 1'b1;
    lat = 0;
    res = '0;
    err = 1'b0;
    for (int k = 1; k <= 100 && to; k++) begin
      if (out_valid) begin
        lat = k;
        res = out_result;
        err = out_err;
        to = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'hFFFF;
    in_b = 16'd1;
    in_opcode = SLL;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({in_ready, out_valid, out_result, out_err, busy} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
    begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b res=%h err=%b busy=%b, want 1 0 0000 0 0",
               in_ready, out_valid, out_result, out_err, busy);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift;
    logic [W-1:0] va[8], vb[8], vr[8];
    logic [3:0]   vo[8];
    logic [W-1:0] res;
    logic         err;
    int           lat;
    bit           ok, to;
    exp_t         e;
    va = '{16'h0001, 16'hFFFF, 16'h00A5, 16'h1234, 16'h8000, 16'h7FFF, 16'h8001, 16'h4000};
    vb = '{16'd3,    16'h0020, 16'd0,    16'd16,   16'd4,    16'd15,   16'hFFFF, 16'd1};
    vo = '{SLL,      SLL,      SLL,      SLL,      SAR,      SAR,      SAR,      SAR};
    vr = '{16'h0008, 16'h0000, 16'h00A5, 16'h0000, 16'hF800, 16'h0000, 16'hFFFF, 16'h2000};
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], vo[i], vr[i], 1'b0, ok);
      collect(res, err, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (!ok || to) begin
        n_fail++;
        $display("FAIL shift_handshake[%0d]: accepted=%0b timeout=%0b, want 1 0", i, ok, to);
      end else begin
        n_checks += 3;
        if (res !== e.res) begin
          n_fail++;
          $display("FAIL shift_result[%0d]: got %h want %h", i, res, e.res);
        end
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL shift_err[%0d]: got %b want %b", i, err, e.err);
        end
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, e.lat);
        end
      end
      ack();
    end
  endtask

  task automatic test_rotate;
    logic [W-1:0] va[5], vb[5], vr[5];
    logic [3:0]   vo[5];
    logic [W-1:0] res;
    logic         err;
    int           lat;
    bit           ok, to;
    exp_t         e;
    va = '{16'h8001, 16'h0001, 16'hBEEF, 16'h8001, 16'h1234};
    vb = '{16'd1,    16'd20,   16'd16,   16'd1,    16'd4};
    vo = '{ROL,      ROR,      ROL,      ROR,      ROL};
    vr = '{16'h0003, 16'h1000, 16'hBEEF, 16'hC000, 16'h2341};
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vo[i], vr[i], 1'b0, ok);
      collect(res, err, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (!ok || to) begin
        n_fail++;
        $display("FAIL rot_handshake[%0d]: accepted=%0b timeout=%0b, want 1 0", i, ok, to);
      end else begin
        n_checks += 3;
        if (res !== e.res) begin
          n_fail++;
          $display("FAIL rot_result[%0d]: got %h want %h", i, res, e.res);
        end
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL rot_err[%0d]: got %b want %b", i, err, e.err);
        end
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL rot_latency[%0d]: got %0d want %0d", i, lat, e.lat);
        end
      end
      ack();
    end
  endtask

  task automatic test_illegal;
    logic [3:0]   vo[3];
    logic [W-1:0] res;
    logic         err;
    int           lat;
    bit           ok, to;
    exp_t         e;
    vo = '{4'b0000, 4'b1111, 4'b0101};
    for (int i = 0; i < 3; i++) begin
      send(16'h1234, 16'd5, vo[i], 16'h0000, 1'b1, ok);
      collect(res, err, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (!ok || to) begin
        n_fail++;
        $display("FAIL illegal_handshake[%0d]: accepted=%0b timeout=%0b, want 1 0", i, ok, to);
      end else begin
        n_checks += 3;
        if (res !== e.res) begin
          n_fail++;
          $display("FAIL illegal_result[%0d]: got %h want %h", i, res, e.res);
        end
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL illegal_err[%0d]: got %b want %b", i, err, e.err);
        end
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL illegal_latency[%0d]: got %0d want %0d", i, lat, e.lat);
        end
      end
      ack();
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, res;
    logic [3:0]   op;
    logic         err;
    int           lat, sel;
    bit           ok, to;
    exp_t         e;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: op = SLL;
        1: op = SAR;
        2: op = ROL;
        3: op = ROR;
        default: op = 4'($urandom_range(10, 15));
      endcase
      b = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
      send(a, b, op, model(a, b, op), !is_legal(op), ok);
      collect(res, err, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (!ok || to) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d]: accepted=%0b timeout=%0b, want 1 0", i, ok, to);
      end else begin
        n_checks += 3;
        if (res !== e.res) begin
          n_fail++;
          $display("FAIL rand_result[%0d] a=%h b=%h op=%b: got %h want %h",
                   i, a, b, op, res, e.res);
        end
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL rand_err[%0d]: got %b want %b", i, err, e.err);
        end
        if (lat != e.lat) begin
          n_fail++;
          $display("FAIL rand_latency[%0d] b=%h op=%b: got %0d want %0d", i, b, op, lat, e.lat);
        end
      end
      ack();
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] res;
    logic         err;
    int           lat;
    bit           ok, to, stable;
    exp_t         e, e2;
    send(16'h00F0, 16'd2, SLL, 16'h03C0, 1'b0, ok);
    collect(res, err, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (!ok || to || res !== e.res) begin
      n_fail++;
      $display("FAIL bp_first_result: got %h (acc=%0b to=%0b) want %h", res, ok, to, e.res);
    end
    // Second command offered while the first result is stalled.
    e2.res = 16'h8001;
    e2.err = 1'b0;
    e2.lat = lat_of(16'd1, ROR);
    sb.push_back(e2);
    in_a = 16'h0003;
    in_b = 16'd1;
    in_opcode = ROR;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b1 || out_result !== e.res || out_err !== 1'b0 || in_ready !== 1'b0)
        stable = 1'b0;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_stall_stable: got vld=%b res=%h rdy=%b, want 1 %h 0",
               out_valid, out_result, in_ready, e.res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_accept_on_handshake: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_next_cycle: got busy=%b want 1", busy);
    end
    collect(res, err, lat, to);
    e2 = sb.pop_front();
    n_checks++;
    if (to || res !== e2.res || err !== e2.err || lat != e2.lat) begin
      n_fail++;
      $display("FAIL bp_second_result: got %h err=%b lat=%0d to=%0b want %h %b %0d",
               res, err, lat, to, e2.res, e2.err, e2.lat);
    end
    ack();
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] res;
    logic         err;
    int           lat;
    bit           ok, to, seen;
    exp_t         e;
    send(16'h0001, 16'd10, SLL, 16'h0400, 1'b0, ok);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!ok || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_shift: got acc=%0b busy=%b vld=%b want 1 1 0", ok, busy, out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_result, out_err, busy} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
    begin
      n_fail++;
      $display("FAIL rstmid_values: got rdy=%b vld=%b res=%h err=%b busy=%b, want 1 0 0000 0 0",
               in_ready, out_valid, out_result, out_err, busy);
    end
    sb.delete();  // the aborted result is never presented
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_no_valid: got out_valid pulse=1 want 0");
    end
    send(16'h0001, 16'd10, SLL, 16'h0400, 1'b0, ok);
    collect(res, err, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (!ok || to || res !== e.res || err !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got %h err=%b lat=%0d to=%0b want %h %b %0d",
               res, err, lat, to, e.res, e.err, e.lat);
    end
    ack();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_opcode = '0;
    out_ready = 1'b0;
    test_reset();
    test_shift();
    test_rotate();
    test_illegal();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
